// File: rtl/serial_arith_pkg.sv
// Shared constants for the bit-serial arithmetic blocks: FSM state encoding and default width.
package serial_arith_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned SERIAL_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StRun  = S_RUN,
    StDone = S_DONE
  } serial_state_e;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out. Purely combinational.
module full_subtractor_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial subtractor (diff = a - b - bin) with start/busy/done handshake.
// Optional signed overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  , output logic           ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  serial_state_e state_q, state_d;

  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;

  logic load;
  logic last;
  logic cell_d;
  logic cell_bout;

  full_subtractor_bit u_cell (
    .x    (sa_q[0]),
    .y    (sb_q[0]),
    .bin  (br_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last = (state_q == StRun) && (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        load = start;
      end
      StRun: begin
        sa_d   = {1'b0, sa_q[WIDTH-1:1]};
        sb_d   = {1'b0, sb_q[WIDTH-1:1]};
        diff_d = {cell_d, diff_q[WIDTH-1:1]};
        br_d   = cell_bout;
        if (last) begin
          // Hold the counter at its final value instead of wrapping.
          bout_d  = cell_bout;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        load    = start;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Accepted start: capture operands and begin a fresh run (also from DONE, back-to-back).
    if (load) begin
      sa_d    = a;
      sb_d    = b;
      br_d    = bin;
      cnt_d   = '0;
      diff_d  = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign diff = diff_q;
  assign bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
  logic amsb_q;
  logic bmsb_q;
  logic ovf_q;

  // Operand MSBs are shifted out during the run, so keep copies for the overflow test.
  always_ff @(posedge clk) begin
    if (rst) begin
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (load) begin
        amsb_q <= a[WIDTH-1];
        bmsb_q <= b[WIDTH-1];
      end
      if (last) begin
        ovf_q <= (amsb_q != bmsb_q) && (cell_d != amsb_q);
      end
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=4 against an arithmetic model.
module tb_serial_subtractor;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf4;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf (ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(W4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .bin   (bin4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf (ovf4)
`endif
  );

  function automatic logic [31:0] ref_diff(input int w, input int a, input int b, input int bin);
    int r;
    r = a - b - bin;
    return 32'(r) & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic ref_bout(input int a, input int b, input int bin);
    return a < (b + bin);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w4, input int a, input int b, input int bin, input logic st);
    if (w4) begin
      a4 = 4'(a); b4 = 4'(b); bin4 = 1'(bin); start4 = st;
    end else begin
      a8 = 8'(a); b8 = 8'(b); bin8 = 1'(bin); start8 = st;
    end
  endtask

  function automatic logic [31:0] cur_diff(input bit w4);
    return w4 ? 32'(diff4) : 32'(diff8);
  endfunction

  // One complete operation: accept, scramble inputs, wait (bounded) for done, check, check hold.
  task automatic run_op(input bit w4, input int a, input int b, input int bin, input string tag);
    int w;
    int lat;
    logic [31:0] ed;
    logic eb;
    w  = w4 ? W4 : W8;
    ed = ref_diff(w, a, b, bin);
    eb = ref_bout(a, b, bin);
    drive(w4, a, b, bin, 1'b1);
    step();
    drive(w4, int'($urandom), int'($urandom), int'($urandom_range(1, 0)), 1'b0);
    lat = 0;
    while (!(w4 ? done4 : done8) && lat < w + 4) begin
      chk({tag, " busy"}, 32'(w4 ? busy4 : busy8), 32'd1);
      step();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(w));
    chk({tag, " diff"}, cur_diff(w4), ed);
    chk({tag, " bout"}, 32'(w4 ? bout4 : bout8), 32'(eb));
    chk({tag, " busy_done"}, 32'(w4 ? busy4 : busy8), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, " ovf"}, 32'(w4 ? ovf4 : ovf8),
        32'((ed[w-1] != 1'(a >> (w - 1))) && (1'(a >> (w - 1)) != 1'(b >> (w - 1)))));
`endif
    step();
    chk({tag, " done_pulse"}, 32'(w4 ? done4 : done8), 32'd0);
    chk({tag, " diff_hold"}, cur_diff(w4), ed);
  endtask

  initial begin
    int ea [$];
    int eb [$];
    int n_done;
    int lat;

    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0);
    drive(1'b1, 0, 0, 0, 1'b0);
    step();
    step();
    chk("rst busy", 32'(busy8), 32'd0);
    chk("rst done", 32'(done8), 32'd0);
    chk("rst diff", 32'(diff8), 32'd0);
    chk("rst bout", 32'(bout8), 32'd0);
    chk("rst4 diff", 32'(diff4), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst ovf", 32'(ovf8), 32'd0);
`endif
    rst = 1'b0;
    step();

    run_op(1'b0, 100, 37, 0, "d100_37");
    run_op(1'b0, 5, 10, 0, "d5_10");
    run_op(1'b0, 0, 0, 1, "d0_0_1");
    run_op(1'b0, 255, 0, 0, "d255_0");
    run_op(1'b0, 0, 255, 1, "d0_255_1");
    for (int i = 0; i < 20; i++) begin
      run_op(1'b0, int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
             int'($urandom_range(1, 0)), "rand8");
    end

    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int c = 0; c < 2; c++) begin
          run_op(1'b1, av, bv, c, "exh4");
        end
      end
    end

    // Back-to-back with start held high; inputs scrambled throughout each run.
    ea.push_back(int'($urandom_range(255, 0)));
    eb.push_back(int'($urandom_range(255, 0)));
    drive(1'b0, ea[0], eb[0], 0, 1'b1);
    step();
    for (int k = 0; k < 6; k++) begin
      lat = 0;
      while (!done8 && lat < W8 + 4) begin
        drive(1'b0, int'($urandom), int'($urandom), int'($urandom_range(1, 0)), 1'b1);
        step();
        lat++;
      end
      chk("b2b latency", 32'(lat), 32'(W8));
      chk("b2b diff", 32'(diff8), ref_diff(W8, ea[k], eb[k], 0));
      chk("b2b bout", 32'(bout8), 32'(ref_bout(ea[k], eb[k], 0)));
      ea.push_back(int'($urandom_range(255, 0)));
      eb.push_back(int'($urandom_range(255, 0)));
      drive(1'b0, ea[k+1], eb[k+1], 0, k < 5);
      step();
      if (k < 5) chk("b2b no_gap busy", 32'(busy8), 32'd1);
    end
    step();
    step();

    // Reset mid-operation after four run cycles: abandoned, no done pulse.
    drive(1'b0, 255, 0, 0, 1'b1);
    step();
    drive(1'b0, 255, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy", 32'(busy8), 32'd0);
    chk("midrst done", 32'(done8), 32'd0);
    chk("midrst diff", 32'(diff8), 32'd0);
    chk("midrst bout", 32'(bout8), 32'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) n_done++;
      step();
    end
    chk("midrst no_done", 32'(n_done), 32'd0);
    run_op(1'b0, 77, 200, 1, "after_rst");

    // Reset and start together: reset wins.
    rst = 1'b1;
    drive(1'b0, 9, 3, 0, 1'b1);
    step();
    rst = 1'b0;
    drive(1'b0, 9, 3, 0, 1'b0);
    chk("rst_vs_start busy", 32'(busy8), 32'd0);
    step();
    chk("rst_vs_start idle", 32'(busy8), 32'd0);

`ifdef SERIAL_SUB_OVF_EN
    run_op(1'b0, 'h80, 'h01, 0, "ovf_80_01");
    chk("ovf_80_01 flag", 32'(ovf8), 32'd1);
    run_op(1'b0, 'h10, 'h01, 0, "ovf_10_01");
    chk("ovf_10_01 flag", 32'(ovf8), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- LSB-first bit-serial subtractor: computes diff = a - b - bin over WIDTH clock cycles using one full-subtractor cell and a borrow flip-flop.
- Sequential counterpart to the existing combinational full adder. Provides subtraction for the basic arithmetic library at minimum area.
- Uses a start/done handshake so a bench or controller can chain operations back-to-back.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when the block is not busy.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while the subtraction is running.
- done  output  1  one-cycle pulse when diff and bout are valid.
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset:
  - Synchronous to clk, active-high.
  - Sets state=IDLE and clears busy, done, diff, bout, shift registers, borrow register and bit counter to 0.
  - A reset mid-operation abandons the operation with no done pulse. The first state after reset deasserts is IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE: when start=1, load sa<=a, sb<=b, br<=bin, cnt<=0, diff<=0, then go to RUN. When start=0, stay in IDLE.
  - RUN: busy=1 and start is ignored. Each cycle:
    - d = sa[0]^sb[0]^br.
    - br <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
    - diff <= {d, diff[WIDTH-1:1]}.
    - sa, sb shift right by 1, filling with 0.
    - cnt <= cnt+1.
    - When cnt==WIDTH-1, go to DONE. The last borrow lands in br.
  - DONE: done=1 for exactly this cycle, bout=br, busy=0.
    - With start=1 in DONE, the new operands load immediately and the next state is RUN (back-to-back, no idle gap).
    - Otherwise the next state is IDLE.
- Latency: start is sampled at edge 0. RUN occupies edges 1..WIDTH. done is high in the cycle after edge WIDTH, so start-to-done is WIDTH+1 cycles. Throughput is one result per WIDTH+1 cycles.
- Output stability: diff and bout hold their values from DONE until the next accepted start. diff is not guaranteed meaningful during RUN.
- Counter width: clog2(WIDTH). The counter never wraps beyond WIDTH-1.
- Inputs a, b and bin may change freely after start is accepted; only the captured copies are used.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), a signed two's-complement overflow flag.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), using the captured operand MSBs; valid with done.
  - ovf is 0 on reset and holds its value with diff.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - default width constant SERIAL_WIDTH_DEF=8.
- Sub-module full_subtractor_bit:
  - Purely combinational cell.
  - Inputs x, y, bin; outputs d, bout.
  - Mirrors the existing full adder's interface; instantiated once in the datapath.

Test Plan:
- WIDTH=8, a=100, b=37, bin=0, start pulse -> busy high for 8 cycles; done pulses 9 cycles after start with diff=63, bout=0.
- a=5, b=10, bin=0 -> diff=251 (0xFB), bout=1; then a=0, b=0, bin=1 -> diff=255, bout=1.
- Exhaustive check at WIDTH=4: all 512 (a, b, bin) combinations -> diff == (a-b-bin) mod 16 and bout == (a < b+bin) for every case.
- Hold start=1 continuously with new operands on each DONE -> results back-to-back every 9 cycles. Operand changes and start pulses during RUN are ignored; results match the operands captured at acceptance.
- Assert rst for one cycle at cnt=4 mid-operation -> no done pulse; busy=0, diff=0, bout=0 next cycle; a fresh start afterwards gives the correct result.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, ovf=1; a=0x10, b=0x01 -> diff=0x0F, ovf=0.
